// File: rtl/dma_fifo_param.sv
// Show-ahead synchronous FIFO for the DMA data path: head word is visible on rd_data
// with no read latency, all DEPTH entries usable, sticky overflow/underflow flags.
module dma_fifo_param #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 2,
   localparam int LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [LVL_W-1:0]  level,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AFULL_LVL  = LVL_W'(AFULL_TH);
   localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_TH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [LVL_W-1:0] level_reg, level_next;
   logic             overflow_reg, overflow_next;
   logic             underflow_reg, underflow_next;

   logic wr_ok, wr_acc, rd_acc, ovf_set, udf_set;

   // Flags derive only from the registered level, never from the request inputs.
   assign full         = (level_reg == DEPTH_LVL);
   assign empty        = (level_reg == '0);
   assign almost_full  = (level_reg >= AFULL_LVL);
   assign almost_empty = (level_reg <= AEMPTY_LVL);
   assign level        = level_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   // A full FIFO still takes a write when the head is popped in the same cycle.
   assign wr_ok   = wr_en & (~full | rd_en);
   assign wr_acc  = wr_ok & ~flush;
   assign rd_acc  = rd_en & ~empty & ~flush;
   assign ovf_set = wr_en & ~wr_ok & ~flush;
   assign udf_set = rd_en & empty & ~flush;

   assign rd_data = empty ? '0 : mem[rd_ptr_reg];

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      level_next     = level_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;

      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         level_next  = '0;
      end else begin
         if (wr_acc) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (rd_acc) rd_ptr_next = rd_ptr_reg + 1'b1;
         if (wr_acc && !rd_acc)      level_next = level_reg + 1'b1;
         else if (rd_acc && !wr_acc) level_next = level_reg - 1'b1;
      end

      // A new error event in the clearing cycle must not be lost.
      if (err_clr) begin
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end
      if (ovf_set) overflow_next  = 1'b1;
      if (udf_set) underflow_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         level_reg     <= level_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   // Storage has no reset so it can map onto block/distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem[wr_ptr_reg] <= wr_data;
   end

endmodule

// File: tb/tb_dma_fifo_param.sv
// Directed bench for dma_fifo_param: a vector table for reset/error/bypass cases,
// then hand-written fill, full-with-pop, wrap and flush sequences with a queue model.
module tb_dma_fifo_param;

   logic        clk = 1'b0;
   logic        rst, flush, wr_en, rd_en, err_clr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]  level;

   int checks = 0;
   int errors = 0;

   dma_fifo_param #(.DATA_W(32), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   // ctl = {rst, flush, wr_en, rd_en, err_clr}; flg = {empty, full, almost_full, almost_empty}
   // err = {overflow, underflow}
   typedef struct packed {
      logic [4:0]  ctl;
      logic [31:0] data;
      logic [4:0]  lvl;
      logic [3:0]  flg;
      logic [31:0] rdd;
      logic [1:0]  err;
   } vec_t;

   vec_t vecs [15];
   logic [31:0] q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic f, input logic w, input logic rd,
                      input logic c, input logic [31:0] d);
      rst = r; flush = f; wr_en = w; rd_en = rd; err_clr = c; wr_data = d;
      @(posedge clk);
      #1;
      $display("t=%0t rst=%b flush=%b wr=%b rd=%b clr=%b din=%0h -> lvl=%0d rd_data=%0h e=%b f=%b af=%b ae=%b ovf=%b udf=%b",
               $time, r, f, w, rd, c, d, level, rd_data, empty, full, almost_full,
               almost_empty, overflow, underflow);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{5'b10000, 32'h0,  5'd0, 4'b1001, 32'h0,  2'b00};
      vecs[1]  = '{5'b10000, 32'h0,  5'd0, 4'b1001, 32'h0,  2'b00};
      vecs[2]  = '{5'b00010, 32'h0,  5'd0, 4'b1001, 32'h0,  2'b01};
      vecs[3]  = '{5'b00001, 32'h0,  5'd0, 4'b1001, 32'h0,  2'b00};
      vecs[4]  = '{5'b00110, 32'h11, 5'd1, 4'b0001, 32'h11, 2'b01};
      vecs[5]  = '{5'b00100, 32'h22, 5'd2, 4'b0001, 32'h11, 2'b01};
      vecs[6]  = '{5'b00101, 32'h33, 5'd3, 4'b0000, 32'h11, 2'b00};
      vecs[7]  = '{5'b00010, 32'h0,  5'd2, 4'b0001, 32'h22, 2'b00};
      vecs[8]  = '{5'b00110, 32'h44, 5'd2, 4'b0001, 32'h33, 2'b00};
      vecs[9]  = '{5'b00010, 32'h0,  5'd1, 4'b0001, 32'h44, 2'b00};
      vecs[10] = '{5'b00010, 32'h0,  5'd0, 4'b1001, 32'h0,  2'b00};
      vecs[11] = '{5'b00011, 32'h0,  5'd0, 4'b1001, 32'h0,  2'b01};
      vecs[12] = '{5'b00001, 32'h0,  5'd0, 4'b1001, 32'h0,  2'b00};
      vecs[13] = '{5'b01110, 32'h55, 5'd0, 4'b1001, 32'h0,  2'b00};
      vecs[14] = '{5'b10100, 32'h66, 5'd0, 4'b1001, 32'h0,  2'b00};

      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 32'h0;

      // Table: reset, underflow, no-bypass, set-beats-clear, flush ignores requests
      for (int i = 0; i < 15; i++) begin
         cyc(vecs[i].ctl[4], vecs[i].ctl[3], vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0],
             vecs[i].data);
         chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
         chk($sformatf("v%0d_flags", i), 32'({empty, full, almost_full, almost_empty}),
             32'(vecs[i].flg));
         chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].rdd);
         chk($sformatf("v%0d_errs", i), 32'({overflow, underflow}), 32'(vecs[i].err));
      end

      // Fill to full
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'(32'h100 + i));
         chk($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
         chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 15));
         chk($sformatf("fill%0d_afull", i), 32'(almost_full), 32'(i + 1 >= 12));
         chk($sformatf("fill%0d_empty", i), 32'(empty), 32'h0);
      end
      chk("full_head", rd_data, 32'h100);

      // Write while full without pop is rejected
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD);
      chk("ovf_set", 32'(overflow), 32'h1);
      chk("ovf_level", 32'(level), 32'd16);
      chk("ovf_head", rd_data, 32'h100);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("ovf_clr", 32'(overflow), 32'h0);

      // Write with pop while full
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAA);
      chk("fullrw_level", 32'(level), 32'd16);
      chk("fullrw_ovf", 32'(overflow), 32'h0);
      chk("fullrw_head", rd_data, 32'h101);

      // Clear and new overflow in the same cycle: set wins
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBEEF);
      chk("ovf_setwins", 32'(overflow), 32'h1);
      chk("ovf_setwins_lvl", 32'(level), 32'd16);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("ovf_clr2", 32'(overflow), 32'h0);

      // Drain: 0x101..0x10F then 0xAA
      q.delete();
      for (int i = 1; i < 16; i++) q.push_back(32'(32'h100 + i));
      q.push_back(32'hAA);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d_head", i), rd_data, q[i]);
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      end
      chk("drain_empty", 32'(empty), 32'h1);
      chk("drain_rd_data", rd_data, 32'h0);
      chk("drain_level", 32'(level), 32'h0);
      chk("drain_udf", 32'(underflow), 32'h0);

      // Wrap: hold level at 3..4 across 40 cycles
      q.delete();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'(32'h200 + i));
         q.push_back(32'(32'h200 + i));
      end
      for (int i = 0; i < 40; i++) begin
         logic w, r;
         logic [31:0] d;
         w = (i % 4) != 3;
         r = (i % 4) != 1;
         d = 32'(32'h300 + i);
         cyc(1'b0, 1'b0, w, r, 1'b0, d);
         if (r) void'(q.pop_front());
         if (w) q.push_back(d);
         chk($sformatf("wrap%0d_level", i), 32'(level), 32'(q.size()));
         chk($sformatf("wrap%0d_head", i), rd_data, q[0]);
      end
      chk("wrap_errs", 32'({overflow, underflow}), 32'h0);

      // Drain remainder, raise underflow, then flush mid-stream
      while (q.size() > 0) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
         void'(q.pop_front());
         chk("tail_head", rd_data, (q.size() > 0) ? q[0] : 32'h0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk("udf_set", 32'(underflow), 32'h1);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'(32'h400 + i));
      chk("pre_flush_level", 32'(level), 32'd7);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h77);
      chk("flush_level", 32'(level), 32'h0);
      chk("flush_empty", 32'(empty), 32'h1);
      chk("flush_errs", 32'({overflow, underflow}), 32'b01);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'(32'h500 + i));
      chk("post_flush_level", 32'(level), 32'd9);
      chk("post_flush_head", rd_data, 32'h500);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst9_level", 32'(level), 32'h0);
      chk("rst9_flags", 32'({empty, full, almost_full, almost_empty}), 32'b1001);
      chk("rst9_rd_data", rd_data, 32'h0);
      chk("rst9_errs", 32'({overflow, underflow}), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
